pulse_period_checker: RTL and testbench
=======================================

// Module: pulse_period_checker
// PURPOSE
//  Receive-side monitor for the periodic strobe from the pulse generator. Measures
//  the interval between strobes, declares lock after LOCK_COUNT consecutive in-tolerance
//  intervals, and flags early/late/missing strobes while locked. Sits in the clk domain
//  next to the generator or its consumer; pulse_in is already synchronous to clk.
// PARAMETERS
//  PERIOD      5   expected strobe interval in clk cycles (>=1)
//  TOL         0   allowed +/- deviation in cycles (PERIOD-TOL >= 1)
//  LOCK_COUNT  3   consecutive matching intervals required to enter LOCKED (>=1)
//  CNT_W       8   interval counter width; PERIOD+TOL < 2**CNT_W-1
// PORTS
//  clk         in   1      clock, all logic rising-edge
//  reset       in   1      synchronous, active-high
//  pulse_in    in   1      strobe; every cycle sampled high is one event
//  locked      out  1      high while FSM in LOCKED
//  period_out  out  CNT_W  last measured interval
//  period_vld  out  1      1-cycle pulse when period_out updates
//  err_early   out  1      1-cycle pulse: event with interval < PERIOD-TOL while LOCKED
//  err_late    out  1      1-cycle pulse: no event by interval PERIOD+TOL while LOCKED
//  err_cnt     out  8      saturating count of err_early+err_late pulses
// BEHAVIOUR
//  - Reset: all outputs 0, state SEARCH, cnt=0, match_cnt=0. Reset mid-operation wins over
//    everything; state/outputs are zero from the next edge.
//  - cnt: set to 1 on edge after an event cycle, else +1, saturates at 2**CNT_W-1.
//    Interval of an event = cnt in that cycle (events at cycles 0 and 5 -> interval 5).
//  - match: PERIOD-TOL <= interval <= PERIOD+TOL.
//  - timeout: cycle where cnt == PERIOD+TOL and pulse_in==0 (event in that cycle is a match,
//    not a timeout).
//  - All outputs registered: event/timeout in cycle k -> outputs visible in cycle k+1.
//  - FSM:
//    SEARCH : event -> ACQUIRE, match_cnt=0; no period_vld (no prior reference).
//    ACQUIRE: event -> period_out=interval, period_vld=1; match -> match_cnt+1, reaching
//             LOCK_COUNT -> LOCKED; mismatch -> match_cnt=0 (stay, event is new reference).
//             timeout -> SEARCH, no error flagged.
//    LOCKED : event&match -> period_out/period_vld, stay. event&early -> err_early=1,
//             period_out/period_vld updated, -> ACQUIRE, match_cnt=0.
//             timeout -> err_late=1, -> SEARCH (no period_vld).
//  - err_early and err_late never assert in the same cycle; errors only in LOCKED.
//  - err_cnt +1 per error pulse, holds at 255.
//  - locked = (state==LOCKED), registered; drops in the cycle err_* asserts.
//  - pulse_in constant high with PERIOD=1: every cycle is a matching event.
// STRUCTURE
//  - Shared package generator_pkg: state encoding typedef (SEARCH/ACQUIRE/LOCKED) and
//    default PERIOD localparam shared with the generator.
//  - One sub-module: interval_counter (saturating CNT_W counter, restart-on-event, exposes
//    cnt). FSM, compare and error logic live in pulse_period_checker.
// TESTING
//  1 Generator defaults (strobe every 5, first at cycle 4): period_vld from 2nd strobe,
//    period_out=5; locked=1 the cycle after the 4th strobe; err_cnt stays 0.
//  2 Locked, then strobe at interval 3 -> err_early=1 one cycle, locked=0, err_cnt=1,
//    period_out=3; relock after 3 further interval-5 strobes.
//  3 Locked, strobes stop -> err_late=1 in cycle after cnt==5, state SEARCH, locked=0,
//    no further errors while idle; err_cnt=1.
//  4 TOL=1, intervals 4,6,5,4 -> all match, locked after third, no errors; interval 7
//    while locked -> err_late at cnt==6.
//  5 Reset asserted for 1 cycle while locked with err_cnt=2 -> next cycle all outputs 0,
//    SEARCH; first following strobe gives no period_vld.
//  6 255 alternating early errors -> err_cnt saturates at 255, no wrap.

Source files
------------

// File: rtl/generator_pkg.sv
// Definitions shared between the strobe generator and the period checker.
package generator_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  localparam int unsigned DEFAULT_PERIOD = 5;

endpackage

// File: rtl/pulse_period_checker_interval_counter.sv
// Saturating interval counter: reloads to 1 after an event cycle, otherwise counts up.
module interval_counter
  import generator_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             event_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    cnt_d = sat_inc(cnt_q);
    if (event_i) begin
      cnt_d = CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pulse_period_checker.sv
// Strobe period monitor: measures strobe intervals, locks after LOCK_COUNT matches,
// and flags early/late strobes while locked.
module pulse_period_checker
  import generator_pkg::*;
#(
  parameter int PERIOD     = DEFAULT_PERIOD,
  parameter int TOL        = 0,
  parameter int LOCK_COUNT = 3,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pulse_in,
  output logic             locked,
  output logic [CNT_W-1:0] period_out,
  output logic             period_vld,
  output logic             err_early,
  output logic             err_late,
  output logic [7:0]       err_cnt
);

  localparam int MC_W = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] LO_LIM = CNT_W'(PERIOD - TOL);
  localparam logic [CNT_W-1:0] HI_LIM = CNT_W'(PERIOD + TOL);
  localparam logic [MC_W-1:0]  LAST_MC = MC_W'(LOCK_COUNT - 1);

  logic [CNT_W-1:0] cnt;
  logic             is_match;
  logic             is_early;
  logic             is_timeout;

  state_e           state_q,     state_d;
  logic [MC_W-1:0]  match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0] period_q,    period_d;
  logic             vld_q,       vld_d;
  logic             early_q,     early_d;
  logic             late_q,      late_d;
  logic [7:0]       errcnt_q,    errcnt_d;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (&v) ? v : v + 8'd1;
  endfunction

  interval_counter #(
    .CNT_W (CNT_W)
  ) u_interval_counter (
    .clk     (clk),
    .reset   (reset),
    .event_i (pulse_in),
    .cnt_o   (cnt)
  );

  // An event landing exactly on the upper limit is a match, so timeout needs pulse_in low.
  assign is_match   = (cnt >= LO_LIM) && (cnt <= HI_LIM);
  assign is_early   = (cnt < LO_LIM);
  assign is_timeout = !pulse_in && (cnt == HI_LIM);

  always_comb begin
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    period_d    = period_q;
    vld_d       = 1'b0;
    early_d     = 1'b0;
    late_d      = 1'b0;
    unique case (state_q)
      ST_SEARCH: begin
        if (pulse_in) begin
          state_d     = ST_ACQUIRE;
          match_cnt_d = '0;
        end
      end
      ST_ACQUIRE: begin
        if (pulse_in) begin
          period_d = cnt;
          vld_d    = 1'b1;
          if (is_match) begin
            if (match_cnt_q == LAST_MC) begin
              state_d     = ST_LOCKED;
              match_cnt_d = '0;
            end else begin
              match_cnt_d = match_cnt_q + MC_W'(1);
            end
          end else begin
            match_cnt_d = '0;
          end
        end else if (is_timeout) begin
          state_d     = ST_SEARCH;
          match_cnt_d = '0;
        end
      end
      ST_LOCKED: begin
        if (pulse_in) begin
          period_d = cnt;
          vld_d    = 1'b1;
          if (is_early) begin
            early_d     = 1'b1;
            state_d     = ST_ACQUIRE;
            match_cnt_d = '0;
          end
        end else if (is_timeout) begin
          late_d      = 1'b1;
          state_d     = ST_SEARCH;
          match_cnt_d = '0;
        end
      end
      default: begin
        state_d     = ST_SEARCH;
        match_cnt_d = '0;
      end
    endcase
    errcnt_d = (early_d || late_d) ? sat_inc8(errcnt_q) : errcnt_q;
  end

  // Registered outputs: decisions made in cycle k appear in cycle k+1.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_SEARCH;
      match_cnt_q <= '0;
      period_q    <= '0;
      vld_q       <= 1'b0;
      early_q     <= 1'b0;
      late_q      <= 1'b0;
      errcnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      match_cnt_q <= match_cnt_d;
      period_q    <= period_d;
      vld_q       <= vld_d;
      early_q     <= early_d;
      late_q      <= late_d;
      errcnt_q    <= errcnt_d;
    end
  end

  assign locked     = (state_q == ST_LOCKED);
  assign period_out = period_q;
  assign period_vld = vld_q;
  assign err_early  = early_q;
  assign err_late   = late_q;
  assign err_cnt    = errcnt_q;

endmodule

// File: tb/tb_pulse_period_checker.sv
// Directed bench for pulse_period_checker: default instance plus a TOL=1 instance.
module tb_pulse_period_checker;

  logic       clk;
  logic       reset;
  logic       pulse_a;
  logic       pulse_t;
  logic       sel;

  logic       locked_a, vld_a, early_a, late_a;
  logic [7:0] period_a, errcnt_a;
  logic       locked_t, vld_t, early_t, late_t;
  logic [7:0] period_t, errcnt_t;

  int tests;
  int fails;

  pulse_period_checker #(
    .PERIOD(5), .TOL(0), .LOCK_COUNT(3), .CNT_W(8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pulse_in   (pulse_a),
    .locked     (locked_a),
    .period_out (period_a),
    .period_vld (vld_a),
    .err_early  (early_a),
    .err_late   (late_a),
    .err_cnt    (errcnt_a)
  );

  pulse_period_checker #(
    .PERIOD(5), .TOL(1), .LOCK_COUNT(3), .CNT_W(8)
  ) dut_t (
    .clk        (clk),
    .reset      (reset),
    .pulse_in   (pulse_t),
    .locked     (locked_t),
    .period_out (period_t),
    .period_vld (vld_t),
    .err_early  (early_t),
    .err_late   (late_t),
    .err_cnt    (errcnt_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic p);
    pulse_a = sel ? 1'b0 : p;
    pulse_t = sel ? p : 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic strobe_gap(input int gap);
    repeat (gap - 1) cyc(1'b0);
    cyc(1'b1);
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    sel     = 1'b0;
    reset   = 1'b1;
    pulse_a = 1'b0;
    pulse_t = 1'b0;
    cyc(1'b0);
    cyc(1'b0);
    chk("rst_locked", 32'(locked_a), 0);
    chk("rst_vld", 32'(vld_a), 0);
    chk("rst_period", 32'(period_a), 0);
    chk("rst_errcnt", 32'(errcnt_a), 0);
    chk("rst_early", 32'(early_a), 0);
    chk("rst_late", 32'(late_a), 0);
    reset = 1'b0;

    // 1: strobes every 5 cycles, first at cycle 4
    repeat (4) cyc(1'b0);
    cyc(1'b1);
    chk("t1_first_novld", 32'(vld_a), 0);
    strobe_gap(5);
    chk("t1_vld2", 32'(vld_a), 1);
    chk("t1_period2", 32'(period_a), 5);
    chk("t1_notlocked2", 32'(locked_a), 0);
    cyc(1'b0);
    chk("t1_vld_pulse", 32'(vld_a), 0);
    strobe_gap(4);
    chk("t1_notlocked3", 32'(locked_a), 0);
    strobe_gap(5);
    chk("t1_locked4", 32'(locked_a), 1);
    chk("t1_period4", 32'(period_a), 5);
    chk("t1_errcnt", 32'(errcnt_a), 0);

    // 2: early strobe at interval 3, then relock
    strobe_gap(3);
    chk("t2_early", 32'(early_a), 1);
    chk("t2_late", 32'(late_a), 0);
    chk("t2_unlocked", 32'(locked_a), 0);
    chk("t2_errcnt", 32'(errcnt_a), 1);
    chk("t2_period", 32'(period_a), 3);
    chk("t2_vld", 32'(vld_a), 1);
    cyc(1'b0);
    chk("t2_early_pulse", 32'(early_a), 0);
    strobe_gap(4);
    chk("t2_relock1", 32'(locked_a), 0);
    chk("t2_period_r1", 32'(period_a), 5);
    strobe_gap(5);
    chk("t2_relock2", 32'(locked_a), 0);
    strobe_gap(5);
    chk("t2_relock3", 32'(locked_a), 1);

    // 3: strobes stop while locked
    repeat (4) cyc(1'b0);
    chk("t3_nolate_cnt4", 32'(late_a), 0);
    chk("t3_locked_cnt4", 32'(locked_a), 1);
    cyc(1'b0);
    chk("t3_late", 32'(late_a), 1);
    chk("t3_unlocked", 32'(locked_a), 0);
    chk("t3_noearly", 32'(early_a), 0);
    chk("t3_errcnt", 32'(errcnt_a), 2);
    cyc(1'b0);
    chk("t3_late_pulse", 32'(late_a), 0);
    repeat (20) cyc(1'b0);
    chk("t3_idle_late", 32'(late_a), 0);
    chk("t3_idle_errcnt", 32'(errcnt_a), 2);
    chk("t3_idle_vld", 32'(vld_a), 0);

    // relock with err_cnt = 2
    cyc(1'b1);
    chk("t3_search_novld", 32'(vld_a), 0);
    repeat (3) strobe_gap(5);
    chk("t5_pre_locked", 32'(locked_a), 1);
    chk("t5_pre_errcnt", 32'(errcnt_a), 2);

    // 5: one-cycle reset while locked
    reset = 1'b1;
    cyc(1'b0);
    reset = 1'b0;
    chk("t5_locked", 32'(locked_a), 0);
    chk("t5_errcnt", 32'(errcnt_a), 0);
    chk("t5_period", 32'(period_a), 0);
    chk("t5_vld", 32'(vld_a), 0);
    chk("t5_early", 32'(early_a), 0);
    chk("t5_late", 32'(late_a), 0);
    cyc(1'b0);
    cyc(1'b0);
    cyc(1'b1);
    chk("t5_first_novld", 32'(vld_a), 0);
    strobe_gap(5);
    chk("t5_second_vld", 32'(vld_a), 1);
    chk("t5_second_period", 32'(period_a), 5);
    chk("t5_second_unlocked", 32'(locked_a), 0);

    // 6: repeated early errors saturate err_cnt
    for (int i = 0; i < 260; i++) begin
      repeat (3) strobe_gap(5);
      strobe_gap(3);
      if (i == 0) begin
        chk("t6_errcnt_first", 32'(errcnt_a), 1);
        chk("t6_early_first", 32'(early_a), 1);
      end
      if (i == 253) chk("t6_errcnt_254", 32'(errcnt_a), 254);
      if (i == 254) chk("t6_errcnt_255", 32'(errcnt_a), 255);
      if (i == 259) begin
        chk("t6_errcnt_hold", 32'(errcnt_a), 255);
        chk("t6_early_last", 32'(early_a), 1);
      end
    end

    // 4: TOL=1 instance, intervals 4,6,5,4 then 7
    sel = 1'b1;
    chk("t4_pre_errcnt", 32'(errcnt_t), 0);
    chk("t4_pre_locked", 32'(locked_t), 0);
    cyc(1'b1);
    strobe_gap(4);
    chk("t4_i4_vld", 32'(vld_t), 1);
    chk("t4_i4_period", 32'(period_t), 4);
    strobe_gap(6);
    chk("t4_i6_period", 32'(period_t), 6);
    chk("t4_i6_unlocked", 32'(locked_t), 0);
    strobe_gap(5);
    chk("t4_i5_locked", 32'(locked_t), 1);
    strobe_gap(4);
    chk("t4_i4b_locked", 32'(locked_t), 1);
    chk("t4_i4b_period", 32'(period_t), 4);
    chk("t4_noerr_early", 32'(early_t), 0);
    chk("t4_errcnt0", 32'(errcnt_t), 0);
    repeat (5) cyc(1'b0);
    chk("t4_nolate_cnt5", 32'(late_t), 0);
    chk("t4_locked_cnt5", 32'(locked_t), 1);
    cyc(1'b0);
    chk("t4_late_cnt6", 32'(late_t), 1);
    chk("t4_unlocked", 32'(locked_t), 0);
    chk("t4_errcnt1", 32'(errcnt_t), 1);
    chk("t4_a_quiet", 32'(errcnt_a), 255);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
